// File: rtl/count_monitor.sv
// Monitors a WIDTH-bit up/down counter: classifies each sample, flags wraps and
// direction errors, keeps min/max/wrap statistics and a hysteretic high alarm.
module count_monitor #(
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned HI_THRESH = 24,
   parameter int unsigned LO_THRESH = 8,
   parameter int unsigned WRAP_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              mode,
   input  logic              sample_en,
   input  logic              clr_stats,
   output logic              wrap_up,
   output logic              wrap_down,
   output logic              step_err,
   output logic              dir_err,
   output logic              hi_alarm,
   output logic              stats_valid,
   output logic [WIDTH-1:0]  min_val,
   output logic [WIDTH-1:0]  max_val,
   output logic [WRAP_W-1:0] wrap_count
);

   localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
   localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
   localparam logic [WIDTH-1:0]  HI_LVL   = WIDTH'(HI_THRESH);
   localparam logic [WIDTH-1:0]  LO_LVL   = WIDTH'(LO_THRESH);

   typedef enum logic {IDLE, HIGH} alarm_state_t;

   alarm_state_t     state, state_nxt;
   logic [WIDTH-1:0] prev;
   logic             primed;

   logic [WIDTH-1:0] delta_c;
   logic             take_c, is_up_c, is_dn_c;
   logic             wup_c, wdn_c, step_c, dir_c;

   // Classify the incoming sample relative to the previous one.
   always_comb begin
      delta_c = count_in - prev;
      take_c  = sample_en & ~clr_stats & primed;
      is_up_c = (delta_c == WIDTH'(1));
      is_dn_c = (delta_c == CNT_MAX);
      wup_c   = take_c & is_up_c & (prev == CNT_MAX) & (count_in == '0);
      wdn_c   = take_c & is_dn_c & (prev == '0) & (count_in == CNT_MAX);
      step_c  = take_c & (delta_c != '0) & ~is_up_c & ~is_dn_c;
      dir_c   = take_c & ((is_up_c & ~mode) | (is_dn_c & mode));
   end

   // Alarm next-state: only a live sample can move it; a clear forces IDLE.
   always_comb begin
      state_nxt = state;
      if (clr_stats) begin
         state_nxt = IDLE;
      end else if (sample_en) begin
         case (state)
            IDLE:    if (count_in >= HI_LVL) state_nxt = HIGH;
            HIGH:    if (count_in <= LO_LVL) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_alarm <= 1'b0;
      end else begin
         hi_alarm <= (state_nxt == HIGH);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         prev        <= '0;
         primed      <= 1'b0;
         stats_valid <= 1'b0;
         min_val     <= '0;
         max_val     <= '0;
         wrap_count  <= '0;
         wrap_up     <= 1'b0;
         wrap_down   <= 1'b0;
         step_err    <= 1'b0;
         dir_err     <= 1'b0;
      end else begin
         wrap_up   <= wup_c;
         wrap_down <= wdn_c;
         step_err  <= step_c;
         dir_err   <= dir_c;
         if (clr_stats) begin
            primed      <= 1'b0;
            stats_valid <= 1'b0;
            min_val     <= '0;
            max_val     <= '0;
            wrap_count  <= '0;
         end else if (sample_en) begin
            prev <= count_in;
            if (!primed) begin
               primed      <= 1'b1;
               stats_valid <= 1'b1;
               min_val     <= count_in;
               max_val     <= count_in;
            end else begin
               if (count_in < min_val) min_val <= count_in;
               if (count_in > max_val) max_val <= count_in;
               if ((wup_c | wdn_c) && (wrap_count != WRAP_MAX))
                  wrap_count <= wrap_count + WRAP_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor: a driver pushes model predictions, a
// monitor pops one per cycle and compares every output.
module tb_count_monitor;

   localparam int W    = 5;
   localparam int WW   = 8;
   localparam int MAXV = (1 << W) - 1;
   localparam int WMAX = (1 << WW) - 1;
   localparam int HI   = 24;
   localparam int LO   = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  count_in = '0;
   logic          mode = 1'b0;
   logic          sample_en = 1'b0;
   logic          clr_stats = 1'b0;
   logic          wrap_up, wrap_down, step_err, dir_err, hi_alarm, stats_valid;
   logic [W-1:0]  min_val, max_val;
   logic [WW-1:0] wrap_count;

   count_monitor #(.WIDTH(W), .HI_THRESH(HI), .LO_THRESH(LO), .WRAP_W(WW)) dut (
      .clk(clk), .reset(reset), .count_in(count_in), .mode(mode),
      .sample_en(sample_en), .clr_stats(clr_stats),
      .wrap_up(wrap_up), .wrap_down(wrap_down), .step_err(step_err),
      .dir_err(dir_err), .hi_alarm(hi_alarm), .stats_valid(stats_valid),
      .min_val(min_val), .max_val(max_val), .wrap_count(wrap_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int wu, wd, se, de, ha, sv, mn, mx, wc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   done = 0;

   // Reference model state
   int   m_prev = 0, m_mn = 0, m_mx = 0, m_wraps = 0, m_cur = 0;
   bit   m_primed = 0, m_alarm = 0, m_sv = 0;

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, want);
      end
   endtask

   // One clock of stimulus; the model predicts what the outputs show after the edge.
   task automatic step(input bit rst_n, input bit en, input bit clr, input int c, input bit md);
      exp_t e;
      int d;
      @(negedge clk);
      reset = rst_n; sample_en = en; clr_stats = clr; count_in = W'(c); mode = md;
      e = '{default: 0};
      if (!rst_n) begin
         m_prev = 0; m_primed = 0; m_alarm = 0; m_sv = 0; m_mn = 0; m_mx = 0; m_wraps = 0;
      end else if (clr) begin
         m_primed = 0; m_alarm = 0; m_sv = 0; m_mn = 0; m_mx = 0; m_wraps = 0;
      end else if (en) begin
         if (!m_primed) begin
            m_primed = 1; m_sv = 1; m_mn = c; m_mx = c;
         end else begin
            d = (c - m_prev + MAXV + 1) % (MAXV + 1);
            if (d == 1) begin
               e.wu = (m_prev == MAXV && c == 0);
               e.de = (md == 0);
            end else if (d == MAXV) begin
               e.wd = (m_prev == 0 && c == MAXV);
               e.de = (md == 1);
            end else if (d != 0) begin
               e.se = 1;
            end
            if (c < m_mn) m_mn = c;
            if (c > m_mx) m_mx = c;
            if ((e.wu || e.wd) && m_wraps < WMAX) m_wraps++;
         end
         m_prev = c;
         if (!m_alarm && c >= HI) m_alarm = 1;
         else if (m_alarm && c <= LO) m_alarm = 0;
      end
      e.ha = m_alarm; e.sv = m_sv; e.mn = m_mn; e.mx = m_mx; e.wc = m_wraps;
      sb.push_back(e);
   endtask

   // Monitor: every cycle after the edge, compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wrap_up",     int'(wrap_up),     e.wu);
            chk("wrap_down",   int'(wrap_down),   e.wd);
            chk("step_err",    int'(step_err),    e.se);
            chk("dir_err",     int'(dir_err),     e.de);
            chk("hi_alarm",    int'(hi_alarm),    e.ha);
            chk("stats_valid", int'(stats_valid), e.sv);
            chk("min_val",     int'(min_val),     e.mn);
            chk("max_val",     int'(max_val),     e.mx);
            chk("wrap_count",  int'(wrap_count),  e.wc);
         end
      end
   end

   initial begin
      #2000000;
      if (!done) begin
         $display("FAIL watchdog: got timeout expected completion");
         $fatal(1, "watchdog");
      end
   end

   initial begin
      int seq_up[5]    = '{29, 30, 31, 0, 1};
      int seq_alarm[6] = '{20, 24, 15, 9, 8, 25};
      int r, c;
      bit md;

      // Reset held low while a sample is offered
      repeat (3) step(0, 1, 0, 17, 1);
      step(1, 1, 0, 5, 1);
      step(1, 0, 0, 5, 1);

      foreach (seq_up[i]) step(1, 1, 0, seq_up[i], 1);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 31, 0);
      step(1, 1, 0, 0, 1);
      step(1, 1, 0, 31, 1);

      step(1, 1, 0, 12, 0);
      step(1, 1, 0, 31, 0);
      step(1, 1, 0, 0, 0);

      foreach (seq_alarm[i]) step(1, 1, 0, seq_alarm[i], 1);
      step(1, 0, 0, 3, 1);

      // Clear wins over a concurrent sample, then re-prime
      step(1, 1, 1, 3, 1);
      step(1, 1, 0, 7, 1);
      step(1, 1, 0, 7, 1);

      // Saturate the wrap counter by alternating 31/0
      for (int i = 0; i < 300; i++) step(1, 1, 0, (i % 2 == 0) ? 31 : 0, 1);
      step(1, 0, 0, 0, 1);

      // Randomized phase biased toward legal steps
      m_cur = 0;
      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 3)      c = (m_cur + 1) % (MAXV + 1);
         else if (r <= 6) c = (m_cur + MAXV) % (MAXV + 1);
         else if (r == 7) c = m_cur;
         else             c = $urandom_range(0, MAXV);
         md = ($urandom_range(0, 4) == 0) ? (r > 3) : (r <= 3);
         if ($urandom_range(0, 99) == 0)
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), c, md);
         else if ($urandom_range(0, 39) == 0)
            step(1, $urandom_range(0, 1), 1, c, md);
         else if ($urandom_range(0, 4) == 0)
            step(1, 0, 0, c, md);
         else begin
            step(1, 1, 0, c, md);
            m_cur = c;
         end
      end

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drain", sb.size(), 0);
      done = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
